uart_bist: RTL and testbench
============================

UART_BIST -- requirements
Module: uart_bist

Interface
REQ-001 Parameter DATA_WIDTH, default 8, payload bits per UART word; legal range 5..9.
REQ-002 Parameter FIFO_DEPTH, default 16, expected-data scoreboard entries; power of 2, at least 2.
REQ-003 Parameter CNT_WIDTH, default 16, width of every statistics counter.
REQ-004 Parameter TIMEOUT, default 100000, clk cycles allowed in DRAIN before outstanding words count as lost.
REQ-005 Parameter SEED, default 'h1, LFSR start value, forced to 1 if zero.
REQ-006 Ports, as name / direction / width / meaning:
- clk, input, 1, single clock.
- rst, input, 1, reset; synchronous, active-high.
- i_start, input, 1, pulse that starts a run from IDLE or DONE.
- i_stop, input, 1, pulse that ends generation and enters DRAIN.
- i_mode, input, 2, data mode: 00 incrementing, 01 LFSR, 10 fixed i_pattern, 11 walking-one.
- i_pattern, input, DATA_WIDTH, fixed pattern for mode 10.
- o_tx_vld, output, 1, word offered to the transmitter.
- o_tx_data, output, DATA_WIDTH, offered word.
- i_tx_rdy, input, 1, transmitter accepts the word.
- i_rx_vld, input, 1, received word valid.
- i_rx_data, input, DATA_WIDTH, received word.
- i_rx_pc_pass, input, 1, receiver parity check passed.
- o_rx_rdy, output, 1, always 1 (receive is never stalled).
- o_busy, output, 1, state is RUN or DRAIN.
- o_done, output, 1, state is DONE.
- o_tx_cnt, output, CNT_WIDTH, words accepted by the transmitter.
- o_rx_cnt, output, CNT_WIDTH, words received.
- o_err_cnt, output, CNT_WIDTH, data mismatches plus lost words.
- o_pc_err_cnt, output, CNT_WIDTH, received words with i_rx_pc_pass low.
- o_unexp_cnt, output, CNT_WIDTH, words received while the scoreboard was empty.

Function
REQ-007 FSM states are IDLE, RUN, DRAIN and DONE; there are no other states.
- IDLE to RUN on i_start.
- RUN to DRAIN on i_stop.
- DRAIN to DONE when the scoreboard is empty or the timeout expires.
- DONE to RUN on i_start.
REQ-008 Entering RUN clears all counters, the scoreboard, the timeout counter and the generator; i_mode is sampled and held for the whole run.
REQ-009 o_tx_vld is 1 only in RUN with the scoreboard not full; it drops one cycle after the handshake that fills the scoreboard.
REQ-010 A handshake (o_tx_vld and i_tx_rdy) pushes o_tx_data into the scoreboard, increments o_tx_cnt and advances the generator in the same clk edge.
REQ-011 o_tx_data is stable while o_tx_vld is high and i_tx_rdy is low.
REQ-012 Generator sequences, one step per handshake:
- Incrementing starts at 0 and wraps modulo 2^DATA_WIDTH.
- LFSR is a maximal-length Fibonacci LFSR starting from SEED and never reaches zero.
- Walking-one starts at 1, rotates left, and wraps from the MSB back to bit 0.
REQ-013 i_rx_vld in RUN or DRAIN:
- Increments o_rx_cnt.
- If i_rx_pc_pass is low, increments o_pc_err_cnt.
- If the scoreboard is non-empty, pops the head and increments o_err_cnt when the head differs from i_rx_data.
- If the scoreboard is empty, increments o_unexp_cnt and pops nothing.
REQ-014 A push and a pop in the same cycle are both honoured, including when the scoreboard is full; occupancy is unchanged.
REQ-015 i_rx_vld in IDLE or DONE is ignored.
REQ-016 Simultaneous i_start and i_stop: i_stop wins in RUN; i_start wins in IDLE and DONE.
REQ-017 DRAIN timeout: the counter counts clk cycles in DRAIN and resets on every i_rx_vld. When it reaches TIMEOUT:
- remaining scoreboard occupancy is added to o_err_cnt;
- the scoreboard is flushed;
- the FSM enters DONE.
REQ-018 All counters saturate at all-ones and never wrap.
REQ-019 Counters hold their values in DONE until the next i_start.

Reset
REQ-020 rst is sampled only on the rising edge of clk.
REQ-021 While rst is high: state goes to IDLE; o_tx_vld, o_busy and o_done are 0; all counters are 0; the scoreboard is empty; the generator is reloaded.
REQ-022 rst asserted mid-RUN or mid-DRAIN aborts the run with no residual scoreboard content.

Verification
REQ-023 Ideal loopback, DATA_WIDTH 7, mode 00, 300 words, then i_stop -> DONE; tx_cnt=rx_cnt=300, err, pc_err and unexp all 0.
REQ-024 Receiver stalled, FIFO_DEPTH 16, i_tx_rdy=1 -> exactly 16 handshakes, then o_tx_vld=0 until the first i_rx_vld pop.
REQ-025 Corrupt bit 0 of the 5th received word in mode 01 -> err_cnt=1; all later words match.
REQ-026 i_stop with 3 words outstanding and no rx -> DONE after TIMEOUT cycles with err_cnt=3.
REQ-027 i_rx_vld with the scoreboard empty, and i_rx_pc_pass=0 on one word -> unexp_cnt=1, pc_err_cnt=1.
REQ-028 rst pulse mid-RUN, then i_start -> counters restart at 0; mode 11 sequence restarts at 1.

Source files
------------

// File: rtl/uart_bist.sv
// UART loopback built-in self test.
// Generates a word stream toward a UART transmitter, keeps a copy of every
// accepted word in a small scoreboard FIFO and checks received words against
// it. Statistics counters saturate and hold until the next run is started.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_start, i_stop       run control pulses
//   i_mode, i_pattern     data mode (00 inc, 01 lfsr, 10 fixed, 11 walking-one)
//   o_tx_vld/o_tx_data    word offered to the transmitter, i_tx_rdy accepts it
//   i_rx_vld/i_rx_data    received word, i_rx_pc_pass = parity check result
//   o_rx_rdy              constant 1
//   o_busy, o_done        status (RUN/DRAIN, DONE)
//   o_*_cnt               saturating statistics counters
module uart_bist #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_WIDTH  = 16,
    parameter int unsigned TIMEOUT    = 100000,
    parameter int unsigned SEED       = 'h1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [1:0]            i_mode,
    input  logic [DATA_WIDTH-1:0] i_pattern,
    output logic                  o_tx_vld,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    input  logic                  i_tx_rdy,
    input  logic                  i_rx_vld,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_pc_pass,
    output logic                  o_rx_rdy,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [CNT_WIDTH-1:0]  o_tx_cnt,
    output logic [CNT_WIDTH-1:0]  o_rx_cnt,
    output logic [CNT_WIDTH-1:0]  o_err_cnt,
    output logic [CNT_WIDTH-1:0]  o_pc_err_cnt,
    output logic [CNT_WIDTH-1:0]  o_unexp_cnt
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    // Maximal-length feedback taps for widths 5..9 (x^5+x^3, x^6+x^5, x^7+x^6, x^8+x^6+x^5+x^4, x^9+x^5)
    localparam logic [8:0] TAPS9 = (DATA_WIDTH == 5) ? 9'h014 :
                                   (DATA_WIDTH == 6) ? 9'h030 :
                                   (DATA_WIDTH == 7) ? 9'h060 :
                                   (DATA_WIDTH == 8) ? 9'h0B8 : 9'h110;
    localparam logic [DATA_WIDTH-1:0] TAPS = TAPS9[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] SEED_INIT =
        (DATA_WIDTH'(SEED) == '0) ? DATA_WIDTH'(1) : DATA_WIDTH'(SEED);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                state_q, state_nxt;
    logic [1:0]            mode_q;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]      count_q, count_nxt;
    logic [TO_W-1:0]       to_cnt_q;

    logic                  start_run, timeout_hit, active, rx_fire;
    logic                  push, pop, mismatch, unexp, tx_vld_nxt;
    logic [DATA_WIDTH-1:0] gen_adv;

    assign o_rx_rdy = 1'b1;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v,
                                                      input logic en);
        return (en && (v != '1)) ? v + CNT_WIDTH'(1) : v;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] v,
                                                      input logic [OCC_W-1:0] a);
        logic [CNT_WIDTH:0] s;
        s = {1'b0, v} + (CNT_WIDTH + 1)'(a);
        return s[CNT_WIDTH] ? '1 : s[CNT_WIDTH-1:0];
    endfunction

    // State register plus registered status/valid outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_tx_vld <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            o_busy   <= (state_nxt == RUN) || (state_nxt == DRAIN);
            o_done   <= (state_nxt == DONE);
            o_tx_vld <= tx_vld_nxt;
        end
    end

    // Next state, scoreboard control and next-cycle valid
    always_comb begin
        state_nxt   = state_q;
        start_run   = 1'b0;
        timeout_hit = 1'b0;
        active      = (state_q == RUN) || (state_q == DRAIN);
        rx_fire     = i_rx_vld && active;
        push        = o_tx_vld && i_tx_rdy;
        pop         = rx_fire && (count_q != '0);
        unexp       = rx_fire && (count_q == '0);
        mismatch    = pop && (mem[rd_ptr_q] != i_rx_data);

        case (state_q)
            IDLE, DONE: begin
                if (i_start) begin
                    state_nxt = RUN;
                    start_run = 1'b1;
                end
            end
            RUN: begin
                if (i_stop) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (count_q == '0) begin
                    state_nxt = DONE;
                end else if ((to_cnt_q == TO_W'(TIMEOUT)) && !rx_fire) begin
                    state_nxt   = DONE;
                    timeout_hit = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (start_run || timeout_hit) begin
            count_nxt = '0;
        end else begin
            count_nxt = count_q + OCC_W'(push) - OCC_W'(pop);
        end
        tx_vld_nxt = (state_nxt == RUN) && (count_nxt != OCC_W'(FIFO_DEPTH));
    end

    // Generator step for the held mode; fixed mode simply holds its pattern
    always_comb begin
        gen_adv = o_tx_data;
        case (mode_q)
            2'b00:   gen_adv = o_tx_data + DATA_WIDTH'(1);
            2'b01:   gen_adv = {o_tx_data[DATA_WIDTH-2:0], ^(o_tx_data & TAPS)};
            2'b11:   gen_adv = {o_tx_data[DATA_WIDTH-2:0], o_tx_data[DATA_WIDTH-1]};
            default: gen_adv = o_tx_data;
        endcase
    end

    // Word generator; mode and first word are captured when a run starts
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q    <= 2'b00;
            o_tx_data <= '0;
        end else if (start_run) begin
            mode_q <= i_mode;
            case (i_mode)
                2'b00:   o_tx_data <= '0;
                2'b01:   o_tx_data <= SEED_INIT;
                2'b10:   o_tx_data <= i_pattern;
                default: o_tx_data <= DATA_WIDTH'(1);
            endcase
        end else if (push) begin
            o_tx_data <= gen_adv;
        end
    end

    // Scoreboard storage (no reset needed, pointers define validity)
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= o_tx_data;
    end

    // Scoreboard pointers and occupancy; flushed on run start and timeout
    always_ff @(posedge clk) begin
        if (rst || start_run || timeout_hit) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_nxt;
        end
    end

    // Drain timeout: counts DRAIN cycles, restarted by any received word
    always_ff @(posedge clk) begin
        if (rst || (state_q != DRAIN) || rx_fire) begin
            to_cnt_q <= '0;
        end else if (to_cnt_q != TO_W'(TIMEOUT)) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end

    // Statistics counters
    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            o_tx_cnt     <= '0;
            o_rx_cnt     <= '0;
            o_err_cnt    <= '0;
            o_pc_err_cnt <= '0;
            o_unexp_cnt  <= '0;
        end else begin
            o_tx_cnt     <= sat_inc(o_tx_cnt, push);
            o_rx_cnt     <= sat_inc(o_rx_cnt, rx_fire);
            o_pc_err_cnt <= sat_inc(o_pc_err_cnt, rx_fire && !i_rx_pc_pass);
            o_unexp_cnt  <= sat_inc(o_unexp_cnt, unexp);
            o_err_cnt    <= timeout_hit ? sat_add(o_err_cnt, count_q)
                                        : sat_inc(o_err_cnt, mismatch);
        end
    end

endmodule

// File: tb/tb_uart_bist.sv
// Directed self-checking bench for uart_bist (7-bit words, 16-entry scoreboard,
// short drain timeout so the lost-word path is reachable quickly).
module tb_uart_bist;

    localparam int unsigned DW = 7;
    localparam int unsigned CW = 16;
    localparam int unsigned TO = 50;

    logic          clk = 1'b0;
    logic          rst, i_start, i_stop, i_tx_rdy, i_rx_vld, i_rx_pc_pass;
    logic [1:0]    i_mode;
    logic [DW-1:0] i_pattern, i_rx_data, o_tx_data;
    logic          o_tx_vld, o_rx_rdy, o_busy, o_done;
    logic [CW-1:0] o_tx_cnt, o_rx_cnt, o_err_cnt, o_pc_err_cnt, o_unexp_cnt;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [DW-1:0] sent_log [512];

    uart_bist #(.DATA_WIDTH(DW), .FIFO_DEPTH(16), .CNT_WIDTH(CW), .TIMEOUT(TO), .SEED(1)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_stop(i_stop),
        .i_mode(i_mode), .i_pattern(i_pattern),
        .o_tx_vld(o_tx_vld), .o_tx_data(o_tx_data), .i_tx_rdy(i_tx_rdy),
        .i_rx_vld(i_rx_vld), .i_rx_data(i_rx_data), .i_rx_pc_pass(i_rx_pc_pass),
        .o_rx_rdy(o_rx_rdy), .o_busy(o_busy), .o_done(o_done),
        .o_tx_cnt(o_tx_cnt), .o_rx_cnt(o_rx_cnt), .o_err_cnt(o_err_cnt),
        .o_pc_err_cnt(o_pc_err_cnt), .o_unexp_cnt(o_unexp_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [1:0] m, input logic [DW-1:0] p);
        i_mode = m; i_pattern = p; i_start = 1'b1;
        step();
        i_start = 1'b0;
    endtask

    task automatic pulse_stop();
        i_stop = 1'b1;
        step();
        i_stop = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cycles);
        cycles = 0;
        while (!o_done && cycles < max) begin
            step();
            cycles++;
        end
    endtask

    // Ideal loopback: each accepted word comes back one cycle later
    task automatic loopback(input int n, input int corrupt_idx, output int got);
        logic [DW-1:0] pend [$];
        int sent, guard;
        sent = 0; got = 0; guard = 0;
        while (got < n && guard < n * 4 + 50) begin
            i_tx_rdy = (sent < n);
            if (pend.size() > 0) begin
                i_rx_vld  = 1'b1;
                i_rx_data = pend.pop_front();
                if (got == corrupt_idx) i_rx_data[0] = ~i_rx_data[0];
                got++;
            end else begin
                i_rx_vld = 1'b0;
            end
            if (o_tx_vld && i_tx_rdy) begin
                pend.push_back(o_tx_data);
                sent_log[sent] = o_tx_data;
                sent++;
            end
            step();
            guard++;
        end
        i_tx_rdy = 1'b0;
        i_rx_vld = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] lfsr_exp [8];
        logic [DW-1:0] walk_exp [8];
        logic [DW-1:0] cap [8];
        int got, cyc, hs;

        lfsr_exp = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};
        walk_exp = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h01};

        rst = 1'b1; i_start = 1'b1; i_stop = 1'b0; i_mode = 2'b00; i_pattern = '0;
        i_tx_rdy = 1'b0; i_rx_vld = 1'b0; i_rx_data = '0; i_rx_pc_pass = 1'b1;

        // Reset dominates a held start
        repeat (3) step();
        check("rst_tx_vld", 32'(o_tx_vld), 32'd0);
        check("rst_busy",   32'(o_busy),   32'd0);
        check("rst_done",   32'(o_done),   32'd0);
        check("rst_tx_cnt", 32'(o_tx_cnt), 32'd0);
        check("rst_err",    32'(o_err_cnt), 32'd0);
        check("rx_rdy",     32'(o_rx_rdy), 32'd1);
        i_start = 1'b0; rst = 1'b0;
        step();
        check("idle_busy", 32'(o_busy), 32'd0);

        // Ideal loopback, incrementing, 300 words
        pulse_start(2'b00, '0);
        check("run_busy", 32'(o_busy), 32'd1);
        loopback(300, -1, got);
        check("lb_words", 32'(got), 32'd300);
        check("inc_w0",   32'(sent_log[0]),   32'd0);
        check("inc_w127", 32'(sent_log[127]), 32'd127);
        check("inc_wrap", 32'(sent_log[128]), 32'd0);
        check("inc_w299", 32'(sent_log[299]), 32'd43);
        pulse_stop();
        wait_done(10, cyc);
        check("lb_done",   32'(o_done),       32'd1);
        check("lb_busy",   32'(o_busy),       32'd0);
        check("lb_tx_cnt", 32'(o_tx_cnt),     32'd300);
        check("lb_rx_cnt", 32'(o_rx_cnt),     32'd300);
        check("lb_err",    32'(o_err_cnt),    32'd0);
        check("lb_pc",     32'(o_pc_err_cnt), 32'd0);
        check("lb_unexp",  32'(o_unexp_cnt),  32'd0);

        // Receiver stalled: scoreboard fills after exactly 16 handshakes
        pulse_start(2'b00, '0);
        i_tx_rdy = 1'b1; hs = 0;
        for (int i = 0; i < 30; i++) begin
            if (o_tx_vld) hs++;
            step();
        end
        i_tx_rdy = 1'b0;
        check("stall_hs",     32'(hs),       32'd16);
        check("stall_vld",    32'(o_tx_vld), 32'd0);
        check("stall_tx_cnt", 32'(o_tx_cnt), 32'd16);
        i_rx_vld = 1'b1; i_rx_data = 7'd0;
        step();
        i_rx_vld = 1'b0;
        check("pop_vld", 32'(o_tx_vld), 32'd1);
        check("pop_rx",  32'(o_rx_cnt), 32'd1);
        // Push and pop together: occupancy stays at 15
        i_tx_rdy = 1'b1; i_rx_vld = 1'b1; i_rx_data = 7'd1;
        step();
        i_rx_vld = 1'b0; i_tx_rdy = 1'b0;
        check("pp_vld",    32'(o_tx_vld),  32'd1);
        check("pp_tx_cnt", 32'(o_tx_cnt),  32'd17);
        check("pp_err",    32'(o_err_cnt), 32'd0);
        i_tx_rdy = 1'b1;
        step();
        i_tx_rdy = 1'b0;
        check("refill_vld", 32'(o_tx_vld), 32'd0);
        // Abort with a full scoreboard
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_vld",  32'(o_tx_vld), 32'd0);
        check("abort_busy", 32'(o_busy),   32'd0);
        check("abort_tx",   32'(o_tx_cnt), 32'd0);

        // LFSR loopback with bit 0 of the 5th received word flipped
        pulse_start(2'b01, '0);
        loopback(20, 4, got);
        for (int i = 0; i < 8; i++) check($sformatf("lfsr_w%0d", i), 32'(sent_log[i]), 32'(lfsr_exp[i]));
        pulse_stop();
        wait_done(10, cyc);
        check("lfsr_done", 32'(o_done),    32'd1);
        check("lfsr_rx",   32'(o_rx_cnt),  32'd20);
        check("lfsr_err",  32'(o_err_cnt), 32'd1);

        // Walking one, then reset mid-run restarts the sequence
        pulse_start(2'b11, '0);
        i_tx_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cap[i] = o_tx_data;
            step();
        end
        i_tx_rdy = 1'b0;
        for (int i = 0; i < 8; i++) check($sformatf("walk_w%0d", i), 32'(cap[i]), 32'(walk_exp[i]));
        rst = 1'b1;
        step();
        rst = 1'b0;
        pulse_start(2'b11, '0);
        check("restart_data", 32'(o_tx_data), 32'd1);
        check("restart_tx",   32'(o_tx_cnt),  32'd0);
        check("restart_vld",  32'(o_tx_vld),  32'd1);

        // Three words outstanding, nothing received: lost after the timeout
        i_tx_rdy = 1'b1;
        repeat (3) step();
        i_tx_rdy = 1'b0;
        check("to_tx", 32'(o_tx_cnt), 32'd3);
        pulse_stop();
        wait_done(TO + 20, cyc);
        check("to_done",  32'(o_done), 32'd1);
        check("to_late",  32'(cyc >= TO && cyc <= TO + 3), 32'd1);
        check("to_err",   32'(o_err_cnt), 32'd3);
        check("to_rx",    32'(o_rx_cnt),  32'd0);

        // Unexpected word and a parity failure, fixed pattern mode
        pulse_start(2'b10, 7'h55);
        i_rx_vld = 1'b1; i_rx_data = 7'h2A;
        step();
        i_rx_vld = 1'b0;
        check("unexp_cnt", 32'(o_unexp_cnt), 32'd1);
        check("unexp_err", 32'(o_err_cnt),   32'd0);
        check("fix_w0",    32'(o_tx_data),   32'h55);
        i_tx_rdy = 1'b1;
        repeat (2) step();
        i_tx_rdy = 1'b0;
        check("fix_w2",  32'(o_tx_data), 32'h55);
        check("fix_tx",  32'(o_tx_cnt),  32'd2);
        i_rx_vld = 1'b1; i_rx_data = 7'h55; i_rx_pc_pass = 1'b0;
        step();
        i_rx_pc_pass = 1'b1;
        step();
        i_rx_vld = 1'b0;
        check("pc_cnt",  32'(o_pc_err_cnt), 32'd1);
        check("pc_err",  32'(o_err_cnt),    32'd0);
        check("pc_rx",   32'(o_rx_cnt),     32'd3);
        pulse_stop();
        wait_done(10, cyc);
        check("fix_done", 32'(o_done), 32'd1);
        i_rx_vld = 1'b1;
        step();
        i_rx_vld = 1'b0;
        check("done_rx_ignored", 32'(o_rx_cnt), 32'd3);

        // Start and stop together: start wins in DONE, stop wins in RUN
        i_mode = 2'b00; i_start = 1'b1; i_stop = 1'b1;
        step();
        check("ss_done_busy", 32'(o_busy),   32'd1);
        check("ss_done_rx",   32'(o_rx_cnt), 32'd0);
        step();
        i_start = 1'b0; i_stop = 1'b0;
        check("ss_run_vld",  32'(o_tx_vld), 32'd0);
        check("ss_run_busy", 32'(o_busy),   32'd1);
        step();
        check("ss_drain_done", 32'(o_done), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
